schedule_read_mq: RTL and testbench

SCHEDULE_READ_MQ -- requirements
Module: schedule_read_mq

---
 rtl/schedule_read_mq.sv | 214 +++++++++++++++++++++
 tb/tb_schedule_read_mq.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/schedule_read_mq.sv
// ---------------------------------------------------------------------------
// schedule_read_mq
//
// Splits a host read command (ID, 48-bit start address, byte length) into a
// sequence of page read commands. The first page starts at the latched column
// offset; every later page starts at column 0 of the next row
// (row base + ROW_STEP). The number of issued-but-not-completed page reads is
// limited to MAX_OUTST. The host command completes after every page has been
// issued and every issued page has reported completion.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   o_cmd_ready         : host command accept (high in IDLE only)
//   i_cmd_valid         : host command valid
//   i_rcmd_id           : command ID
//   i_raddr             : start address, [15:0] is the column byte offset
//   i_rlen              : total bytes to read
//   i_page_buf_ready    : page buffer has space for another page
//   o_page_cmd_valid    : page command valid (held until accepted)
//   i_page_cmd_ready    : page command accept
//   o_page_cmd          : page opcode
//   o_page_cmd_last     : final page of the host command
//   o_page_cmd_id       : command ID of the page
//   o_page_addr         : page address
//   o_page_cmd_param    : {chunk[15:0], 12'h800, 3'h6, 1'b1}
//   i_page_done         : one-cycle pulse per completed page read
//   o_outst             : outstanding page reads
//   o_cmd_done          : one-cycle host command completion pulse
//   o_cmd_err           : one-cycle host command rejection pulse
// ---------------------------------------------------------------------------
module schedule_read_mq #(
    parameter int unsigned PAGE_BYTES = 16384,
    parameter logic [47:0] ROW_STEP   = 48'h10000,
    parameter int unsigned MAX_OUTST  = 4,
    parameter int unsigned LEN_W      = 24
) (
    input  logic             clk,
    input  logic             rst,
    output logic             o_cmd_ready,
    input  logic             i_cmd_valid,
    input  logic [15:0]      i_rcmd_id,
    input  logic [47:0]      i_raddr,
    input  logic [LEN_W-1:0] i_rlen,
    input  logic             i_page_buf_ready,
    output logic             o_page_cmd_valid,
    input  logic             i_page_cmd_ready,
    output logic [15:0]      o_page_cmd,
    output logic             o_page_cmd_last,
    output logic [15:0]      o_page_cmd_id,
    output logic [47:0]      o_page_addr,
    output logic [31:0]      o_page_cmd_param,
    input  logic             i_page_done,
    output logic [3:0]       o_outst,
    output logic             o_cmd_done,
    output logic             o_cmd_err
);

    // Chunk arithmetic width: wide enough for the length and for a full page.
    localparam int unsigned CW = (LEN_W > 17) ? LEN_W : 17;

    localparam logic [15:0] PAGE_OPCODE = 16'h3000;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain
    } state_e;

    // State registers
    state_e           r_state;
    logic [15:0]      r_id;
    logic [47:0]      r_addr;
    logic [LEN_W-1:0] r_remain;
    logic             r_first;
    logic [3:0]       r_outst;
    logic             r_hold;
    logic             r_done;
    logic             r_err;

    // Next-state values
    state_e           w_state_d;
    logic [15:0]      w_id_d;
    logic [47:0]      w_addr_d;
    logic [LEN_W-1:0] w_remain_d;
    logic             w_first_d;
    logic [3:0]       w_outst_d;
    logic             w_done_d;
    logic             w_err_d;

    // Datapath
    logic [15:0]      w_col;
    logic [CW-1:0]    w_avail;
    logic [CW-1:0]    w_remain_ext;
    logic [CW-1:0]    w_chunk;
    logic             w_last;
    logic             w_credit;
    logic             w_valid;
    logic             w_hs;
    logic             w_dec;
    logic             w_accept;
    logic             w_col_bad;

    // Only the first page of a command honours the column offset.
    assign w_col        = r_first ? r_addr[15:0] : 16'h0000;
    assign w_avail      = CW'(PAGE_BYTES) - CW'(w_col);
    assign w_remain_ext = CW'(r_remain);
    assign w_chunk      = (w_remain_ext < w_avail) ? w_remain_ext : w_avail;
    assign w_last       = (w_chunk == w_remain_ext);

    assign w_credit  = (32'(r_outst) < MAX_OUTST);
    // Once offered, a page stays valid until taken, even if buffer/credit drop.
    assign w_valid   = (r_state == StIssue) && (r_hold || (i_page_buf_ready && w_credit));
    assign w_hs      = w_valid && i_page_cmd_ready;
    // Completions with nothing outstanding (e.g. stale after reset) are dropped.
    assign w_dec     = i_page_done && (r_outst != 4'd0);
    assign w_accept  = i_cmd_valid && (r_state == StIdle);
    assign w_col_bad = ({16'h0000, i_raddr[15:0]} >= PAGE_BYTES);

    // Next-state logic
    always_comb begin
        w_state_d  = r_state;
        w_id_d     = r_id;
        w_addr_d   = r_addr;
        w_remain_d = r_remain;
        w_first_d  = r_first;
        w_done_d   = 1'b0;
        w_err_d    = 1'b0;

        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_id_d     = i_rcmd_id;
                    w_addr_d   = i_raddr;
                    w_remain_d = i_rlen;
                    w_first_d  = 1'b1;
                    if (w_col_bad) begin
                        w_err_d = 1'b1;
                    end else if (i_rlen == '0) begin
                        w_done_d = 1'b1;
                    end else begin
                        w_state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (w_hs) begin
                    w_remain_d = r_remain - LEN_W'(w_chunk);
                    // Next row starts at column 0; address wraps modulo 2^48.
                    w_addr_d   = {r_addr[47:16], 16'h0000} + ROW_STEP;
                    w_first_d  = 1'b0;
                    if (w_last) begin
                        w_state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (r_outst == 4'd0) begin
                    w_state_d = StIdle;
                    w_done_d  = 1'b1;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Outstanding counter: issue and completion in one cycle cancel out.
    always_comb begin
        w_outst_d = r_outst;
        if (w_hs && !w_dec) begin
            w_outst_d = r_outst + 4'd1;
        end else if (!w_hs && w_dec) begin
            w_outst_d = r_outst - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_id     <= '0;
            r_addr   <= '0;
            r_remain <= '0;
            r_first  <= 1'b0;
            r_outst  <= '0;
            r_hold   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_id     <= w_id_d;
            r_addr   <= w_addr_d;
            r_remain <= w_remain_d;
            r_first  <= w_first_d;
            r_outst  <= w_outst_d;
            r_hold   <= w_valid && !i_page_cmd_ready;
            r_done   <= w_done_d;
            r_err    <= w_err_d;
        end
    end

    // Payload is forced to zero whenever no page is offered.
    assign o_cmd_ready      = (r_state == StIdle);
    assign o_page_cmd_valid = w_valid;
    assign o_page_cmd       = w_valid ? PAGE_OPCODE : 16'h0000;
    assign o_page_cmd_last  = w_valid && w_last;
    assign o_page_cmd_id    = w_valid ? r_id : 16'h0000;
    assign o_page_addr      = w_valid ? r_addr : 48'h0;
    assign o_page_cmd_param = w_valid ? {w_chunk[15:0], 12'h800, 3'h6, 1'b1} : 32'h0;
    assign o_outst          = r_outst;
    assign o_cmd_done       = r_done;
    assign o_cmd_err        = r_err;

endmodule

// File: tb/tb_schedule_read_mq.sv
// ---------------------------------------------------------------------------
// tb_schedule_read_mq
//
// Directed bench for schedule_read_mq (MAX_OUTST=2, other parameters default).
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// falling edge so combinational page-valid has settled.
// ---------------------------------------------------------------------------
module tb_schedule_read_mq;

    logic        clk;
    logic        rst;
    logic        o_cmd_ready;
    logic        i_cmd_valid;
    logic [15:0] i_rcmd_id;
    logic [47:0] i_raddr;
    logic [23:0] i_rlen;
    logic        i_page_buf_ready;
    logic        o_page_cmd_valid;
    logic        i_page_cmd_ready;
    logic [15:0] o_page_cmd;
    logic        o_page_cmd_last;
    logic [15:0] o_page_cmd_id;
    logic [47:0] o_page_addr;
    logic [31:0] o_page_cmd_param;
    logic        i_page_done;
    logic [3:0]  o_outst;
    logic        o_cmd_done;
    logic        o_cmd_err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] cur_id;

    schedule_read_mq #(
        .PAGE_BYTES(16384),
        .ROW_STEP  (48'h10000),
        .MAX_OUTST (2),
        .LEN_W     (24)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .o_cmd_ready     (o_cmd_ready),
        .i_cmd_valid     (i_cmd_valid),
        .i_rcmd_id       (i_rcmd_id),
        .i_raddr         (i_raddr),
        .i_rlen          (i_rlen),
        .i_page_buf_ready(i_page_buf_ready),
        .o_page_cmd_valid(o_page_cmd_valid),
        .i_page_cmd_ready(i_page_cmd_ready),
        .o_page_cmd      (o_page_cmd),
        .o_page_cmd_last (o_page_cmd_last),
        .o_page_cmd_id   (o_page_cmd_id),
        .o_page_addr     (o_page_addr),
        .o_page_cmd_param(o_page_cmd_param),
        .i_page_done     (i_page_done),
        .o_outst         (o_outst),
        .o_cmd_done      (o_cmd_done),
        .o_cmd_err       (o_cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a falling edge; command accepted on the rising edge between.
    task automatic send_cmd(input logic [15:0] id, input logic [47:0] addr,
                            input logic [23:0] len);
        #1;
        chk("send.ready", o_cmd_ready, 1'b1);
        cur_id      = id;
        i_rcmd_id   = id;
        i_raddr     = addr;
        i_rlen      = len;
        i_cmd_valid = 1'b1;
        @(negedge clk);
        i_cmd_valid = 1'b0;
    endtask

    // Waits for an offered page, checks it, and lets it be taken (ready must be 1).
    task automatic expect_page(input string tag, input logic [47:0] addr,
                               input logic [31:0] param, input logic last);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (o_page_cmd_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, ".valid"}, seen, 1'b1);
        if (seen) begin
            chk({tag, ".addr"}, o_page_addr, addr);
            chk({tag, ".param"}, o_page_cmd_param, param);
            chk({tag, ".last"}, o_page_cmd_last, last);
            chk({tag, ".id"}, o_page_cmd_id, cur_id);
            chk({tag, ".op"}, o_page_cmd, 16'h3000);
            @(negedge clk);
        end
    endtask

    task automatic pulse_done();
        i_page_done = 1'b1;
        @(negedge clk);
        i_page_done = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cnt;
        int errs;
        cnt  = 0;
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (o_cmd_done) cnt++;
            if (o_cmd_err) errs++;
            @(negedge clk);
        end
        chk({tag, ".done_cnt"}, cnt, 1);
        chk({tag, ".err_cnt"}, errs, 0);
    endtask

    initial begin
        int hs;
        int dn;

        rst              = 1'b1;
        i_cmd_valid      = 1'b0;
        i_rcmd_id        = '0;
        i_raddr          = '0;
        i_rlen           = '0;
        i_page_buf_ready = 1'b1;
        i_page_cmd_ready = 1'b1;
        i_page_done      = 1'b0;
        cur_id           = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst.ready", o_cmd_ready, 1'b1);
        chk("rst.valid", o_page_cmd_valid, 1'b0);
        chk("rst.outst", o_outst, 4'd0);
        chk("rst.done", o_cmd_done, 1'b0);
        chk("rst.err", o_cmd_err, 1'b0);
        chk("rst.op", o_page_cmd, 16'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Aligned multi-page with a credit stall before page 3
        send_cmd(16'h0011, 48'h0005_0000, 24'd40000);
        #1;
        chk("t1.latency", o_page_cmd_valid, 1'b1);
        expect_page("t1.p1", 48'h0005_0000, 32'h4000_800D, 1'b0);
        expect_page("t1.p2", 48'h0006_0000, 32'h4000_800D, 1'b0);
        #1;
        chk("t1.stall_valid", o_page_cmd_valid, 1'b0);
        chk("t1.stall_outst", o_outst, 4'd2);
        pulse_done();
        expect_page("t1.p3", 48'h0007_0000, 32'h1C40_800D, 1'b1);
        #1;
        chk("t1.outst", o_outst, 4'd2);
        chk("t1.not_ready", o_cmd_ready, 1'b0);
        pulse_done();
        pulse_done();
        wait_done("t1");

        // Unaligned start
        send_cmd(16'h0022, 48'h0002_3000, 24'd10000);
        expect_page("t2.p1", 48'h0002_3000, 32'h1000_800D, 1'b0);
        expect_page("t2.p2", 48'h0003_0000, 32'h1710_800D, 1'b1);
        pulse_done();
        pulse_done();
        wait_done("t2");

        // Credit stall: 5 pages, no completions
        send_cmd(16'h0033, 48'h0010_0000, 24'd81920);
        hs = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (o_page_cmd_valid && i_page_cmd_ready) hs++;
            @(negedge clk);
        end
        chk("t3.hs_before", hs, 2);
        #1;
        chk("t3.stall_valid", o_page_cmd_valid, 1'b0);
        pulse_done();
        hs = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (o_page_cmd_valid && i_page_cmd_ready) hs++;
            @(negedge clk);
        end
        chk("t3.hs_after_one_done", hs, 1);
        hs = 0;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (o_page_cmd_valid && i_page_cmd_ready) hs++;
            if (o_cmd_done) dn++;
            i_page_done = (o_outst != 4'd0);
            @(negedge clk);
        end
        i_page_done = 1'b0;
        chk("t3.hs_rest", hs, 2);
        chk("t3.done_cnt", dn, 1);

        // Backpressure, no withdrawal, address wrap, handshake + done together
        i_page_cmd_ready = 1'b0;
        send_cmd(16'h0044, 48'hFFFF_FFFF_0000, 24'd20000);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4.hold_valid", o_page_cmd_valid, 1'b1);
            chk("t4.hold_addr", o_page_addr, 48'hFFFF_FFFF_0000);
            chk("t4.hold_param", o_page_cmd_param, 32'h4000_800D);
            chk("t4.hold_last", o_page_cmd_last, 1'b0);
            if (i == 2) i_page_buf_ready = 1'b0;
            @(negedge clk);
        end
        i_page_cmd_ready = 1'b1;
        @(negedge clk);
        i_page_buf_ready = 1'b1;
        #1;
        chk("t4.outst1", o_outst, 4'd1);
        expect_page("t4.p2", 48'h0, 32'h0E20_800D, 1'b1);
        // expect_page took page 2 on the edge just passed; retake the same
        // cycle shape explicitly for the simultaneous case below.
        chk("t4.outst2", o_outst, 4'd2);
        pulse_done();
        #1;
        chk("t4.outst_after_done", o_outst, 4'd1);
        pulse_done();
        wait_done("t4");

        // Simultaneous handshake and completion leaves o_outst unchanged
        send_cmd(16'h0045, 48'h0008_0000, 24'd40000);
        expect_page("t4b.p1", 48'h0008_0000, 32'h4000_800D, 1'b0);
        #1;
        chk("t4b.pre_outst", o_outst, 4'd1);
        chk("t4b.pre_valid", o_page_cmd_valid, 1'b1);
        i_page_done = 1'b1;
        @(negedge clk);
        i_page_done = 1'b0;
        #1;
        chk("t4b.same_cycle_outst", o_outst, 4'd1);
        expect_page("t4b.p3", 48'h000A_0000, 32'h1C40_800D, 1'b1);
        pulse_done();
        pulse_done();
        wait_done("t4b");

        // Zero length: done one clock after accept, no page
        send_cmd(16'h0055, 48'h0000_1000, 24'd0);
        #1;
        chk("t5.len0_done", o_cmd_done, 1'b1);
        chk("t5.len0_valid", o_page_cmd_valid, 1'b0);
        chk("t5.len0_ready", o_cmd_ready, 1'b1);
        @(negedge clk);
        #1;
        chk("t5.len0_done_off", o_cmd_done, 1'b0);
        chk("t5.len0_valid2", o_page_cmd_valid, 1'b0);

        // Column out of range: error pulse, no page
        send_cmd(16'h0056, 48'h0000_4000, 24'd100);
        #1;
        chk("t5.err", o_cmd_err, 1'b1);
        chk("t5.err_done", o_cmd_done, 1'b0);
        chk("t5.err_valid", o_page_cmd_valid, 1'b0);
        @(negedge clk);
        #1;
        chk("t5.err_off", o_cmd_err, 1'b0);
        chk("t5.err_valid2", o_page_cmd_valid, 1'b0);

        // Last legal column: one-byte first page
        send_cmd(16'h0057, 48'h0000_3FFF, 24'd10);
        expect_page("t5.p1", 48'h0000_3FFF, 32'h0001_800D, 1'b0);
        expect_page("t5.p2", 48'h0001_0000, 32'h0009_800D, 1'b1);
        pulse_done();
        pulse_done();
        wait_done("t5");

        // Reset mid-issue after one of three pages
        send_cmd(16'h0066, 48'h0005_0000, 24'd40000);
        expect_page("t6.p1", 48'h0005_0000, 32'h4000_800D, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6.valid", o_page_cmd_valid, 1'b0);
        chk("t6.ready", o_cmd_ready, 1'b1);
        chk("t6.outst", o_outst, 4'd0);
        chk("t6.addr", o_page_addr, 48'h0);
        chk("t6.param", o_page_cmd_param, 32'h0);
        chk("t6.id", o_page_cmd_id, 16'h0);
        chk("t6.last", o_page_cmd_last, 1'b0);
        chk("t6.done", o_cmd_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        pulse_done();
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (o_cmd_done) dn++;
            @(negedge clk);
        end
        chk("t6.stale_outst", o_outst, 4'd0);
        chk("t6.no_done", dn, 0);
        send_cmd(16'h0077, 48'h0002_3000, 24'd10000);
        expect_page("t6.n1", 48'h0002_3000, 32'h1000_800D, 1'b0);
        expect_page("t6.n2", 48'h0003_0000, 32'h1710_800D, 1'b1);
        pulse_done();
        pulse_done();
        wait_done("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
